video_timing_controller: RTL

- Raster scan sequencer for the GPU display path.
- Drives a horizontal pixel counter and a vertical line counter, each with its own phase FSM. Produces sync, data-enable, pixel coordinates and frame/line strobes for the framebuffer reader and the VGA output stage.
- `enable` acts as the pixel-clock tick and pauses/resumes the raster without losing position.

---
 rtl/video_timing_pkg.sv | 57 +++++
 rtl/video_timing_controller_axis.sv | 81 ++++++++
 rtl/video_timing_controller.sv | 122 ++++++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// Shared types and helpers for the raster timing generator.
// phase_t enumerates the four phases every scan axis walks through.
// phase_len returns the length of a phase for a given axis geometry.
// next_phase returns the following phase and skips phases of zero length.
package video_timing_pkg;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_t;

    function automatic int unsigned phase_len(input phase_t ph, input int unsigned active,
                                              input int unsigned fp, input int unsigned sync,
                                              input int unsigned bp);
        int unsigned len;
        case (ph)
            PH_ACTIVE: len = active;
            PH_FRONT:  len = fp;
            PH_SYNC:   len = sync;
            PH_BACK:   len = bp;
            default:   len = active;
        endcase
        return len;
    endfunction

    function automatic phase_t succ_phase(input phase_t ph);
        phase_t nxt;
        case (ph)
            PH_ACTIVE: nxt = PH_FRONT;
            PH_FRONT:  nxt = PH_SYNC;
            PH_SYNC:   nxt = PH_BACK;
            PH_BACK:   nxt = PH_ACTIVE;
            default:   nxt = PH_ACTIVE;
        endcase
        return nxt;
    endfunction

    // At most three successive phases can be empty, so three skip attempts
    // always land on a phase with a non-zero length.
    function automatic phase_t next_phase(input phase_t ph, input int unsigned active,
                                          input int unsigned fp, input int unsigned sync,
                                          input int unsigned bp);
        phase_t nxt;
        nxt = succ_phase(ph);
        for (int i = 0; i < 3; i++) begin
            if (phase_len(nxt, active, fp, sync, bp) == 32'd0) begin
                nxt = succ_phase(nxt);
            end else begin
                nxt = nxt;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/video_timing_controller_axis.sv
// timing_axis: one scan axis (horizontal or vertical).
// Ports: clk, rst (sync, active-high), step (advance one position),
//        pos (current position), phase (current phase), wrap (step taken
//        on the last position of the axis; position returns to 0).
// The phase FSM uses a down-counter holding the positions remaining in the
// current phase, so the FSM never needs wide compares against position.
module timing_axis
    import video_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = 4,
    parameter int unsigned FP     = 1,
    parameter int unsigned SYNC   = 2,
    parameter int unsigned BP     = 1,
    localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP,
    localparam int unsigned PW    = $clog2(TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    output logic [PW-1:0] pos,
    output phase_t        phase,
    output logic          wrap
);

    localparam int unsigned CW = $clog2(TOTAL + 1);

    logic [PW-1:0] pos_r;
    logic [PW-1:0] pos_nxt_s;
    phase_t        phase_r;
    phase_t        phase_nxt_s;
    phase_t        phase_succ_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          at_end_s;

    assign at_end_s = (pos_r == PW'(TOTAL - 1));

    // Next-state: advance position, and change phase when the counter is on its last count.
    always_comb begin
        pos_nxt_s    = pos_r;
        phase_nxt_s  = phase_r;
        cnt_nxt_s    = cnt_r;
        phase_succ_s = next_phase(phase_r, ACTIVE, FP, SYNC, BP);
        if (step) begin
            if (at_end_s) begin
                pos_nxt_s = {PW{1'b0}};
            end else begin
                pos_nxt_s = pos_r + PW'(1);
            end
            if (cnt_r == CW'(1)) begin
                phase_nxt_s = phase_succ_s;
                cnt_nxt_s   = CW'(phase_len(phase_succ_s, ACTIVE, FP, SYNC, BP));
            end else begin
                cnt_nxt_s = cnt_r - CW'(1);
            end
        end else begin
            pos_nxt_s = pos_r;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_r   <= {PW{1'b0}};
            phase_r <= PH_ACTIVE;
            cnt_r   <= CW'(ACTIVE);
        end else begin
            pos_r   <= pos_nxt_s;
            phase_r <= phase_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Outputs.
    always_comb begin
        pos   = pos_r;
        phase = phase_r;
        wrap  = step && at_end_s;
    end

endmodule

// File: rtl/video_timing_controller.sv
// video_timing_controller: raster scan sequencer.
// Ports: clk, rst (sync, active-high, wins over enable), enable (pixel tick),
//        hsync/vsync (active level SYNC_POL), de (visible pixel), x/y
//        (visible coordinates, 0 outside the visible area), line_start and
//        frame_start (one-cycle strobes for the pixel on the outputs).
// All outputs are registered: each enabled edge publishes the decode of the
// position that was current before that edge.
module video_timing_controller
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        SYNC_POL = 1'b0,
    localparam int unsigned XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
    localparam int unsigned YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);

    localparam int unsigned HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int unsigned VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

    logic [HW-1:0] h_pos_s;
    logic [VW-1:0] v_pos_s;
    phase_t        h_phase_s;
    phase_t        v_phase_s;
    logic          h_wrap_s;
    logic          v_step_s;
    logic          unused_v_wrap_s;

    logic          hsync_s, vsync_s, de_s, line_start_s, frame_start_s;
    logic [XW-1:0] x_s;
    logic [YW-1:0] y_s;

    logic          hsync_r, vsync_r, de_r, line_start_r, frame_start_r;
    logic [XW-1:0] x_r;
    logic [YW-1:0] y_r;

    assign v_step_s = enable && h_wrap_s;

    timing_axis #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h (
        .clk   (clk),
        .rst   (rst),
        .step  (enable),
        .pos   (h_pos_s),
        .phase (h_phase_s),
        .wrap  (h_wrap_s)
    );

    timing_axis #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v (
        .clk   (clk),
        .rst   (rst),
        .step  (v_step_s),
        .pos   (v_pos_s),
        .phase (v_phase_s),
        .wrap  (unused_v_wrap_s)
    );

    // Decode of the current raster position.
    always_comb begin
        de_s    = (h_phase_s == PH_ACTIVE) && (v_phase_s == PH_ACTIVE);
        hsync_s = (h_phase_s == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        vsync_s = (v_phase_s == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        if (de_s) begin
            x_s = XW'(h_pos_s);
            y_s = YW'(v_pos_s);
        end else begin
            x_s = {XW{1'b0}};
            y_s = {YW{1'b0}};
        end
        line_start_s  = (h_pos_s == {HW{1'b0}});
        frame_start_s = line_start_s && (v_pos_s == {VW{1'b0}});
    end

    // Output registers: load the decode on enabled edges, hold levels and kill strobes when paused.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_r       <= ~SYNC_POL;
            vsync_r       <= ~SYNC_POL;
            de_r          <= 1'b0;
            x_r           <= {XW{1'b0}};
            y_r           <= {YW{1'b0}};
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else if (enable) begin
            hsync_r       <= hsync_s;
            vsync_r       <= vsync_s;
            de_r          <= de_s;
            x_r           <= x_s;
            y_r           <= y_s;
            line_start_r  <= line_start_s;
            frame_start_r <= frame_start_s;
        end else begin
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end
    end

    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign de          = de_r;
    assign x           = x_r;
    assign y           = y_r;
    assign line_start  = line_start_r;
    assign frame_start = frame_start_r;

endmodule
